// File: rtl/imem_pkg.sv
// Shared definitions for the instruction-fetch slice: FSM encodings,
// instruction width, default reset PC / halt word and a range helper.
package imem_pkg;

  localparam int ILEN = 16;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;
  localparam logic [1:0] ST_HALT = 2'd3;

  localparam logic [15:0] RESET_PC_DEF   = 16'h0000;
  localparam logic [15:0] HALT_INSTR_DEF = 16'hFFFF;

  // A byte address is inside memory when every bit above the word index is 0.
  // Shifting (rather than slicing) keeps this legal when AW+1 == 16.
  function automatic logic pc_in_range(input logic [15:0] pc, input int aw);
    return (pc >> (aw + 1)) == 16'd0;
  endfunction

endpackage

// File: rtl/imem_loader_port.sv
// Boot-loader write port: owns the load word counter and drives the
// instruction memory write port while the controller is in LOAD.
module imem_loader_port
  import imem_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            active,
  input  logic            load_valid,
  input  logic [15:0]     load_data,
  input  logic            load_last,
  output logic            load_ready,
  output logic            imem_we,
  output logic [AW-1:0]   imem_waddr,
  output logic [15:0]     imem_wdata,
  output logic            done
);

  logic [AW-1:0] cnt_q, cnt_d;
  logic          accept;

  // Accept a word whenever LOAD is active; finish on last word or full memory.
  always_comb begin
    accept = active & load_valid;
    done   = accept & (load_last | (cnt_q == AW'(DEPTH - 1)));
    cnt_d  = cnt_q;
    if (done)        cnt_d = '0;
    else if (accept) cnt_d = cnt_q + AW'(1);
  end

  // Counter register; reset aborts any partial load back to address 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign load_ready = active;
  assign imem_we    = accept;
  assign imem_waddr = cnt_q;
  assign imem_wdata = accept ? load_data : '0;

endmodule

// File: rtl/imem_fetch_ctrl.sv
// Fetch-stage controller: FSM, program counter and registered fetch output
// for the 16-bit core; delegates the boot-load write port to a sub-module.
module imem_fetch_ctrl
  import imem_pkg::*;
#(
  parameter int          DEPTH      = 16,
  parameter int          AW         = $clog2(DEPTH),
  parameter logic [15:0] RESET_PC   = RESET_PC_DEF,
  parameter logic [15:0] HALT_INSTR = HALT_INSTR_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load_valid,
  input  logic [15:0]     load_data,
  input  logic            load_last,
  output logic            load_ready,
  output logic            imem_we,
  output logic [AW-1:0]   imem_waddr,
  output logic [15:0]     imem_wdata,
  output logic [15:0]     pc,
  input  logic [15:0]     instr_in,
  input  logic            start,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [15:0]     redirect_pc,
  output logic            if_valid,
  output logic [15:0]     if_instr,
  output logic [15:0]     if_pc,
  output logic            running,
  output logic            halted,
  output logic            fault
);

  logic [1:0]      state_q, state_d;
  logic [15:0]     pc_q, pc_d;
  logic [ILEN-1:0] if_instr_q, if_instr_d;
  logic [15:0]     if_pc_q, if_pc_d;
  logic            if_valid_q, if_valid_d;
  logic            fault_q, fault_d;
  logic            load_done;

  imem_loader_port #(.DEPTH(DEPTH), .AW(AW)) u_loader (
    .clk        (clk),
    .rst_n      (rst_n),
    .active     (state_q == ST_LOAD),
    .load_valid (load_valid),
    .load_data  (load_data),
    .load_last  (load_last),
    .load_ready (load_ready),
    .imem_we    (imem_we),
    .imem_waddr (imem_waddr),
    .imem_wdata (imem_wdata),
    .done       (load_done)
  );

  // Next-state, pc and fetch-register logic; redirect beats stall, range
  // check beats halt decode (instr_in is meaningless out of range).
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    if_instr_d = if_instr_q;
    if_pc_d    = if_pc_q;
    if_valid_d = if_valid_q;
    fault_d    = fault_q;
    case (state_q)
      ST_IDLE: begin
        if (load_valid) begin
          state_d = ST_LOAD;
        end else if (start) begin
          state_d = ST_RUN;
          pc_d    = RESET_PC & 16'hFFFE;
          if (RESET_PC[0]) fault_d = 1'b1;
        end
      end
      ST_LOAD: begin
        if (load_done) state_d = ST_IDLE;
      end
      ST_RUN: begin
        if (redirect_valid) begin
          pc_d       = {redirect_pc[15:1], 1'b0};
          if_valid_d = 1'b0;
          if (redirect_pc[0]) fault_d = 1'b1;
        end else if (!stall) begin
          if (!pc_in_range(pc_q, AW)) begin
            fault_d    = 1'b1;
            state_d    = ST_HALT;
            if_valid_d = 1'b0;
          end else if (instr_in == HALT_INSTR) begin
            state_d    = ST_HALT;
            if_valid_d = 1'b0;
          end else begin
            if_instr_d = instr_in;
            if_pc_d    = pc_q;
            if_valid_d = 1'b1;
            pc_d       = pc_q + 16'd2;
          end
        end
      end
      default: begin
        if_valid_d = 1'b0;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      pc_q       <= RESET_PC;
      if_instr_q <= '0;
      if_pc_q    <= '0;
      if_valid_q <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      if_instr_q <= if_instr_d;
      if_pc_q    <= if_pc_d;
      if_valid_q <= if_valid_d;
      fault_q    <= fault_d;
    end
  end

  assign pc       = pc_q;
  assign if_instr = if_instr_q;
  assign if_pc    = if_pc_q;
  assign if_valid = if_valid_q;
  assign fault    = fault_q;
  assign running  = (state_q == ST_RUN);
  assign halted   = (state_q == ST_HALT);

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Directed bench for imem_fetch_ctrl with a behavioural instruction memory
// and scoreboards for memory writes and delivered instructions.
module tb_imem_fetch_ctrl;

  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          load_valid, load_last, load_ready;
  logic [15:0]   load_data;
  logic          imem_we;
  logic [AW-1:0] imem_waddr;
  logic [15:0]   imem_wdata, pc, instr_in;
  logic          start, stall, redirect_valid;
  logic [15:0]   redirect_pc;
  logic          if_valid;
  logic [15:0]   if_instr, if_pc;
  logic          running, halted, fault;

  typedef struct packed { logic [15:0] a; logic [15:0] d; } pair_t;
  pair_t wq[$];
  pair_t fq[$];
  pair_t wp, fp;

  logic [15:0] mem [DEPTH];
  logic [15:0] ld_addr;
  logic        prev_valid;
  logic [15:0] prev_pc;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  assign instr_in = mem[pc[AW:1]];

  imem_fetch_ctrl #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .load_valid(load_valid), .load_data(load_data), .load_last(load_last),
    .load_ready(load_ready),
    .imem_we(imem_we), .imem_waddr(imem_waddr), .imem_wdata(imem_wdata),
    .pc(pc), .instr_in(instr_in),
    .start(start), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
    .running(running), .halted(halted), .fault(fault)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    ld_addr = 16'd0;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic load_word(input logic [15:0] w, input logic last);
    load_valid = 1'b1;
    load_data  = w;
    load_last  = last;
    for (int i = 0; i < 8 && !load_ready; i++) tick();
    check("ld_ready", load_ready, 1'b1);
    wq.push_back('{a: ld_addr, d: w});
    ld_addr = last ? 16'd0 : ld_addr + 16'd1;
    tick();
    load_valid = 1'b0;
    load_last  = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    check("start_running", running, 1'b1);
    check("start_pc", pc, 16'h0000);
  endtask

  // Memory model capture and scoreboard comparison, sampled mid-cycle.
  always @(negedge clk) begin
    if (imem_we) begin
      mem[imem_waddr] = imem_wdata;
      check("wr_pending", wq.size() > 0, 1'b1);
      if (wq.size() > 0) begin
        wp = wq.pop_front();
        check("wr_addr", 32'(imem_waddr), 32'(wp.a));
        check("wr_data", imem_wdata, wp.d);
      end
    end
    if (if_valid && !(prev_valid && if_pc == prev_pc)) begin
      check("if_pending", fq.size() > 0, 1'b1);
      if (fq.size() > 0) begin
        fp = fq.pop_front();
        check("if_pc", if_pc, fp.a);
        check("if_instr", if_instr, fp.d);
      end
    end
    prev_valid = if_valid;
    prev_pc    = if_pc;
  end

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = 16'h0A00 | 16'(i);
    prev_valid = 1'b0; prev_pc = 16'd0; ld_addr = 16'd0;
    rst_n = 1'b0; load_valid = 1'b0; load_data = '0; load_last = 1'b0;
    start = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    tick(); tick();
    // reset state
    check("rst_pc", pc, 16'h0000);
    check("rst_if_valid", if_valid, 1'b0);
    check("rst_if_instr", if_instr, 16'h0000);
    check("rst_running", running, 1'b0);
    check("rst_halted", halted, 1'b0);
    check("rst_fault", fault, 1'b0);
    check("rst_load_ready", load_ready, 1'b0);
    check("rst_imem_we", imem_we, 1'b0);
    rst_n = 1'b1;
    tick();

    // load four-word program
    load_word(16'h0070, 1'b0);
    load_word(16'h00F0, 1'b0);
    load_word(16'h000E, 1'b0);
    load_word(16'hFFFF, 1'b1);
    check("ld_done_ready", load_ready, 1'b0);
    check("ld_done_we", imem_we, 1'b0);
    check("ld_wq_empty", wq.size(), 0);

    // straight-line run to halt
    fq.push_back('{a: 16'h0, d: 16'h0070});
    fq.push_back('{a: 16'h2, d: 16'h00F0});
    fq.push_back('{a: 16'h4, d: 16'h000E});
    do_start();
    tick(); check("run_pc2", pc, 16'h0002);
    tick(); check("run_pc4", pc, 16'h0004);
    tick(); check("run_pc6", pc, 16'h0006);
    check("run_not_halted", halted, 1'b0);
    tick();
    check("halt_halted", halted, 1'b1);
    check("halt_running", running, 1'b0);
    check("halt_pc", pc, 16'h0006);
    check("halt_if_valid", if_valid, 1'b0);
    tick();
    check("halt_hold_pc", pc, 16'h0006);
    check("run_fq_empty", fq.size(), 0);

    // stall for three cycles at pc=4
    do_reset();
    fq.push_back('{a: 16'h0, d: 16'h0070});
    fq.push_back('{a: 16'h2, d: 16'h00F0});
    fq.push_back('{a: 16'h4, d: 16'h000E});
    do_start();
    tick(); tick();
    check("stall_pre_pc", pc, 16'h0004);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_pc", pc, 16'h0004);
      check("stall_if_instr", if_instr, 16'h00F0);
      check("stall_if_valid", if_valid, 1'b1);
    end
    stall = 1'b0;
    tick();
    check("stall_resume_pc", pc, 16'h0006);
    check("stall_resume_instr", if_instr, 16'h000E);
    tick();
    check("stall_halted", halted, 1'b1);
    check("stall_fq_empty", fq.size(), 0);

    // redirect over stall, misaligned redirect, out-of-range redirect
    do_reset();
    check("rr_fault_clear", fault, 1'b0);
    fq.push_back('{a: 16'h0000, d: 16'h0070});
    fq.push_back('{a: 16'h0014, d: 16'h0A0A});
    fq.push_back('{a: 16'h0016, d: 16'h0A0B});
    do_start();
    tick();
    stall = 1'b1; redirect_valid = 1'b1; redirect_pc = 16'h0014;
    tick();
    check("redir_pc", pc, 16'h0014);
    check("redir_flush", if_valid, 1'b0);
    check("redir_fault", fault, 1'b0);
    stall = 1'b0; redirect_valid = 1'b0;
    tick(); check("redir_pc16", pc, 16'h0016);
    tick(); check("redir_instr", if_instr, 16'h0A0B);
    redirect_valid = 1'b1; redirect_pc = 16'h0007;
    tick();
    check("mis_pc", pc, 16'h0006);
    check("mis_fault", fault, 1'b1);
    check("mis_running", running, 1'b1);
    check("mis_if_valid", if_valid, 1'b0);
    redirect_pc = 16'h0040;
    tick();
    check("oor_pc", pc, 16'h0040);
    check("oor_not_halted", halted, 1'b0);
    redirect_valid = 1'b0;
    tick();
    check("oor_halted", halted, 1'b1);
    check("oor_fault", fault, 1'b1);
    check("oor_if_valid", if_valid, 1'b0);
    check("rr_fq_empty", fq.size(), 0);

    // reset in the middle of a load, then restart at address 0
    do_reset();
    load_word(16'hAAAA, 1'b0);
    load_word(16'hBBBB, 1'b0);
    check("midld_ready", load_ready, 1'b1);
    rst_n = 1'b0;
    ld_addr = 16'd0;
    #1;
    check("midld_rst_ready", load_ready, 1'b0);
    check("midld_rst_we", imem_we, 1'b0);
    tick();
    rst_n = 1'b1;
    tick();
    load_word(16'hCCCC, 1'b1);
    check("reld_ready", load_ready, 1'b0);
    check("reld_wq_empty", wq.size(), 0);
    check("reld_mem0", mem[0], 16'hCCCC);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
